nios_solo_pio_edge: RTL and testbench

NIOS_SOLO_PIO_EDGE -- requirements
Module: nios_solo_pio_edge

---
 rtl/nios_solo_pio_pkg.sv | 30 +++
 rtl/nios_solo_pio_sync.sv | 33 +++
 rtl/nios_solo_pio_edge.sv | 131 +++++++++++++
 tb/tb_nios_solo_pio_edge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_solo_pio_pkg.sv
// Shared constants for the PIO-with-edge-capture block: register map
// addresses, edge/irq mode encodings and the post-reset settle limit.
package nios_solo_pio_pkg;

  // Avalon-MM word addresses of the register map
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  // EDGE_MODE encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // IRQ_MODE encodings
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  // Settle counter value at which edge detection becomes enabled
  localparam logic [1:0] SETTLE_DONE = 2'd3;

  // A bus write happens when the slave is selected and write_n is low
  function automatic logic bus_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/nios_solo_pio_sync.sv
// Two-flop synchronizer chain for asynchronous pin inputs.
module nios_solo_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] stage_q, stage_d;

  // Next-state: shift the pins one stage down the chain
  always_comb begin
    meta_d  = d;
    stage_d = meta_q;
  end

  // Chain registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= '0;
      stage_q <= '0;
    end else begin
      meta_q  <= meta_d;
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/nios_solo_pio_edge.sv
// Avalon-MM parallel I/O port with direction control, edge capture with
// write-1-to-clear flags, set/clear output aliases and a level or edge irq.
module nios_solo_pio_edge
  import nios_solo_pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               EDGE_MODE = 0,
  parameter int               IRQ_MODE  = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in_q, prev_in_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [1:0]       settle_q, settle_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             unused_wdata;

  // Bits of writedata above WIDTH have no destination
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign wr_en        = bus_write(chipselect, write_n);

  nios_solo_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  // Edge detector comparing synchronized input with its one-cycle-old copy
  always_comb begin
    edge_vec = sync_in & ~prev_in_q;
    case (EDGE_MODE)
      EDGE_FALLING: edge_vec = ~sync_in & prev_in_q;
      EDGE_ANY:     edge_vec = sync_in ^ prev_in_q;
      default:      edge_vec = sync_in & ~prev_in_q;
    endcase
  end

  // Register-file next state, irq source and registered read mux
  always_comb begin
    prev_in_d = sync_in;
    data_d    = data_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    ecap_d    = ecap_q;
    settle_d  = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 2'd1;

    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_d = wdata;
        ADDR_DIRECTION: dir_d  = wdata;
        ADDR_IRQMASK:   mask_d = wdata;
        ADDR_EDGECAP:   ecap_d = ecap_q & ~wdata;
        ADDR_OUTSET:    data_d = data_q | wdata;
        ADDR_OUTCLEAR:  data_d = data_q & ~wdata;
        default:        ;
      endcase
    end

    // New edges are applied after the clear so a coincident edge wins;
    // pins are ignored until the synchronizer has flushed its reset zeros.
    if (settle_q == SETTLE_DONE) begin
      ecap_d = ecap_d | edge_vec;
    end

    if (IRQ_MODE == IRQ_EDGE) begin
      irq_d = |(ecap_q & mask_q);
    end else begin
      irq_d = |(sync_in & mask_q);
    end

    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d[WIDTH-1:0] = sync_in;
      ADDR_DIRECTION: readdata_d[WIDTH-1:0] = dir_q;
      ADDR_IRQMASK:   readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP:   readdata_d[WIDTH-1:0] = ecap_q;
      default:        readdata_d = '0;
    endcase
  end

  // State registers; reset takes priority over any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_in_q  <= '0;
      data_q     <= RESET_OUT;
      dir_q      <= '0;
      mask_q     <= '0;
      ecap_q     <= '0;
      settle_q   <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      prev_in_q  <= prev_in_d;
      data_q     <= data_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      ecap_q     <= ecap_d;
      settle_q   <= settle_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_solo_pio_edge.sv
// Self-checking bench: three WIDTH=8 variants (rising/level, any/edge,
// falling/level) tracked by a behavioural model, plus WIDTH=32 and WIDTH=4
// instances for the width-masking corner cases.
module tb_nios_solo_pio_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_bus;

  logic [2:0][31:0] rd;
  logic [2:0][7:0]  outp;
  logic [2:0][7:0]  oen;
  logic [2:0]       irqv;

  logic [31:0] rd_c, outp_c, oen_c;
  logic        irq_c;
  logic [31:0] rd_d;
  logic [3:0]  outp_d, oen_d;
  logic        irq_d;

  int checks = 0;
  int errors = 0;

  nios_solo_pio_edge #(.WIDTH(8), .EDGE_MODE(0), .IRQ_MODE(0), .RESET_OUT(8'h00)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_bus[7:0]), .out_port(outp[0]), .out_en(oen[0]), .irq(irqv[0]));

  nios_solo_pio_edge #(.WIDTH(8), .EDGE_MODE(2), .IRQ_MODE(1), .RESET_OUT(8'h5A)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_bus[7:0]), .out_port(outp[1]), .out_en(oen[1]), .irq(irqv[1]));

  nios_solo_pio_edge #(.WIDTH(8), .EDGE_MODE(1), .IRQ_MODE(0), .RESET_OUT(8'hFF)) u_e (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_bus[7:0]), .out_port(outp[2]), .out_en(oen[2]), .irq(irqv[2]));

  nios_solo_pio_edge #(.WIDTH(32), .EDGE_MODE(0), .IRQ_MODE(0), .RESET_OUT(32'h0)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c),
    .in_port(in_bus), .out_port(outp_c), .out_en(oen_c), .irq(irq_c));

  nios_solo_pio_edge #(.WIDTH(4), .EDGE_MODE(0), .IRQ_MODE(0), .RESET_OUT(4'h0)) u_d (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_d),
    .in_port(in_bus[3:0]), .out_port(outp_d), .out_en(oen_d), .irq(irq_d));

  // ---------------- behavioural model ----------------
  // Pin history: pin value seen at the last three clock edges since reset;
  // the readable value lags the pin by two edges, the "previous" by three.
  logic [7:0] h0, h1, h2;
  int         edges_since_rst;
  logic [2:0][7:0]  m_out, m_dir, m_mask, m_ec;
  logic [2:0]       m_irq;
  logic [2:0][31:0] m_rd;
  bit               model_live = 1'b0;

  function automatic logic [7:0] reset_out_of(int k);
    case (k)
      1:       return 8'h5A;
      2:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Bits that changed in the direction instance k watches for
  function automatic logic [7:0] edges_of(int k, logic [7:0] now_v, logic [7:0] old_v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (k == 0 && now_v[i] == 1'b1 && old_v[i] == 1'b0) r[i] = 1'b1;
      if (k == 2 && now_v[i] == 1'b0 && old_v[i] == 1'b1) r[i] = 1'b1;
      if (k == 1 && now_v[i] != old_v[i])                 r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] clr_bits(logic cs, logic wn, logic [2:0] a, logic [31:0] d);
    return (cs && !wn && a == 3'd3) ? d[7:0] : 8'h00;
  endfunction

  always @(posedge clk) begin
    model_live <= 1'b1;
    if (reset) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      edges_since_rst <= 0;
      for (int k = 0; k < 3; k++) begin
        m_out[k]  <= reset_out_of(k);
        m_dir[k]  <= '0;
        m_mask[k] <= '0;
        m_ec[k]   <= '0;
        m_irq[k]  <= 1'b0;
        m_rd[k]   <= '0;
      end
    end else begin
      h0 <= in_bus[7:0];
      h1 <= h0;
      h2 <= h1;
      if (edges_since_rst < 3) edges_since_rst <= edges_since_rst + 1;
      for (int k = 0; k < 3; k++) begin
        case (address)
          3'd0:    m_rd[k] <= {24'h0, h1};
          3'd1:    m_rd[k] <= {24'h0, m_dir[k]};
          3'd2:    m_rd[k] <= {24'h0, m_mask[k]};
          3'd3:    m_rd[k] <= {24'h0, m_ec[k]};
          default: m_rd[k] <= 32'h0;
        endcase
        m_irq[k] <= (k == 1) ? |(m_ec[k] & m_mask[k]) : |(h1 & m_mask[k]);
        m_ec[k]  <= (m_ec[k] & ~clr_bits(chipselect, write_n, address, writedata))
                  | ((edges_since_rst >= 3) ? edges_of(k, h1, h2) : 8'h00);
        if (chipselect && !write_n) begin
          if (address == 3'd0) m_out[k]  <= writedata[7:0];
          if (address == 3'd4) m_out[k]  <= m_out[k] | writedata[7:0];
          if (address == 3'd5) m_out[k]  <= m_out[k] & ~writedata[7:0];
          if (address == 3'd1) m_dir[k]  <= writedata[7:0];
          if (address == 3'd2) m_mask[k] <= writedata[7:0];
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of the three modelled instances
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 3; k++) begin
        chk("cmp_readdata", k, rd[k], m_rd[k]);
        chk("cmp_out_port", k, {24'h0, outp[k]}, {24'h0, m_out[k]});
        chk("cmp_out_en",   k, {24'h0, oen[k]},  {24'h0, m_dir[k]});
        chk("cmp_irq",      k, {31'h0, irqv[k]}, {31'h0, m_irq[k]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("WR addr=%0d data=%h", a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0]  vec_a [12];
  logic [31:0] vec_d [12];
  logic [7:0]  vec_in[12];

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_bus = 32'h0;
    idle(3);
    chk("rst_out_port", 0, {24'h0, outp[0]}, 32'h00);
    chk("rst_out_port", 1, {24'h0, outp[1]}, 32'h5A);
    chk("rst_readdata", 0, rd[0], 32'h0);
    chk("rst_irq",      1, {31'h0, irqv[1]}, 32'h0);
    reset = 1'b0;
    idle(4);

    // data / direction write, synchronized input read
    wr(3'd0, 32'hA5);
    wr(3'd1, 32'h0F);
    in_bus  = 32'h3C;
    address = 3'd0;
    idle(3);
    $display("RD addr=0 data=%h", rd[0]);
    chk("data_read",  0, rd[0], 32'h3C);
    chk("out_port",   0, {24'h0, outp[0]}, 32'hA5);
    chk("out_en",     0, {24'h0, oen[0]},  32'h0F);

    // outset / outclear
    wr(3'd0, 32'hA4);
    wr(3'd4, 32'h01);
    chk("outset",   0, {24'h0, outp[0]}, 32'hA5);
    wr(3'd5, 32'h80);
    chk("outclear", 0, {24'h0, outp[0]}, 32'h25);

    // flush earlier edges
    in_bus = 32'h0;
    idle(4);
    wr(3'd3, 32'hFF);
    address = 3'd3;
    idle(2);
    chk("ec_cleared", 0, rd[0], 32'h0);

    // rising edge on bit2 visible in readdata four cycles later
    in_bus = 32'h04;
    idle(3);
    chk("ec_lat3", 0, rd[0], 32'h0);
    idle(1);
    chk("ec_lat4", 0, rd[0], 32'h04);
    in_bus = 32'h0;
    idle(5);
    chk("ec_fall_nochg", 0, rd[0], 32'h04);
    wr(3'd3, 32'h04);
    idle(1);
    chk("ec_w1c", 0, rd[0], 32'h0);

    // edge coincident with write-1-clear: set wins
    in_bus = 32'h04;
    idle(2);
    wr(3'd3, 32'h04);
    idle(1);
    chk("ec_set_wins", 0, rd[0], 32'h04);

    // edge irq on instance B
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h04);
    in_bus = 32'h0;
    idle(3);
    chk("irq_before", 1, {31'h0, irqv[1]}, 32'h0);
    idle(1);
    chk("irq_set",    1, {31'h0, irqv[1]}, 32'h1);
    wr(3'd3, 32'h04);
    idle(1);
    chk("irq_clr",    1, {31'h0, irqv[1]}, 32'h0);

    // reset with concurrent write, pins high throughout
    in_bus = 32'hFF; reset = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h11;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);
    chk("rst_wins", 0, {24'h0, outp[0]}, 32'h00);
    chk("rst_wins", 2, {24'h0, outp[2]}, 32'hFF);
    reset = 1'b0; address = 3'd3;
    idle(8);
    chk("settle_ec", 0, rd[0], 32'h0);
    chk("settle_ec", 1, rd[1], 32'h0);
    chk("settle_ec", 2, rd[2], 32'h0);

    // width masking
    wr(3'd1, 32'hFFFFFFFF);
    chk("w32_out_en", 3, oen_c, 32'hFFFFFFFF);
    address = 3'd1;
    idle(1);
    chk("w4_dir_read", 4, rd_d, 32'h0000000F);
    chk("w8_dir_read", 0, rd[0], 32'h000000FF);

    // directed mixed traffic, reading every address in turn
    vec_a  = '{3'd2, 3'd0, 3'd6, 3'd4, 3'd5, 3'd7, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd3};
    vec_d  = '{32'hF0, 32'h3C, 32'hFF, 32'h81, 32'h0C, 32'h55, 32'h5A, 32'hFF,
               32'h0F, 32'h1234_5600, 32'hFFFF_FF10, 32'h00};
    vec_in = '{8'h00, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'hFF, 8'h81, 8'h18,
               8'h00, 8'hC3, 8'h3C, 8'h99};
    for (int i = 0; i < 12; i++) begin
      in_bus = {24'h0, vec_in[i]};
      wr(vec_a[i], vec_d[i]);
      address = 3'(i % 8);
      idle(3);
      $display("RD addr=%0d a=%h b=%h e=%h", address, rd[0], rd[1], rd[2]);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
